fallthrough_fifo_hash: RTL and testbench



---
 rtl/fallthrough_fifo_hash_if.sv | 30 +++
 rtl/fallthrough_fifo_hash.sv | 119 +++++++++++
 tb/tb_fallthrough_fifo_hash.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/fallthrough_fifo_hash_if.sv
// Bus bundle for fallthrough_fifo_hash: FIFO write/pop handshake plus the
// flow-tuple hash input and its two bloom-filter indices.
interface fallthrough_fifo_hash_if #(
  parameter int WIDTH        = 72,
  parameter int INPUT_WIDTH  = 96,
  parameter int OUTPUT_WIDTH = 19
);
  logic [WIDTH-1:0]        din;
  logic                    wr_en;
  logic                    rd_en;
  logic [WIDTH-1:0]        dout;
  logic                    full;
  logic                    nearly_full;
  logic                    empty;
  logic [INPUT_WIDTH-1:0]  data;
  logic [OUTPUT_WIDTH-1:0] hash_0;
  logic [OUTPUT_WIDTH-1:0] hash_1;

  // Upstream producer / consumer side.
  modport master (
    output din, wr_en, rd_en, data,
    input  dout, full, nearly_full, empty, hash_0, hash_1
  );

  // The FIFO + hash block itself.
  modport slave (
    input  din, wr_en, rd_en, data,
    output dout, full, nearly_full, empty, hash_0, hash_1
  );
endinterface

// File: rtl/fallthrough_fifo_hash.sv
// fallthrough_fifo_hash: first-word-fall-through FIFO ahead of the header
// parser, plus a combinational dual-index hash of a TCP flow tuple for the
// bloom filter. The two halves share only clk and reset.
// Optional macro FIFO_HASH_ERR_CHECK_EN enables simulation-only messages on
// a write while full and a pop while empty; datapath behaviour is unchanged.
module fallthrough_fifo_hash #(
  parameter int WIDTH          = 72,
  parameter int MAX_DEPTH_BITS = 3,
  parameter int INPUT_WIDTH    = 96,
  parameter int OUTPUT_WIDTH   = 19
) (
  input logic                     clk,
  input logic                     reset,
  fallthrough_fifo_hash_if.slave  bus
);

  localparam int DEPTH = 1 << MAX_DEPTH_BITS;
  localparam logic [MAX_DEPTH_BITS:0] DEPTH_CNT   = (MAX_DEPTH_BITS+1)'(DEPTH);
  localparam logic [MAX_DEPTH_BITS:0] NEARLY_CNT  = (MAX_DEPTH_BITS+1)'(DEPTH - 1);
  localparam int NUM_SLICES = (INPUT_WIDTH + OUTPUT_WIDTH - 1) / OUTPUT_WIDTH;
  localparam int PAD_WIDTH  = NUM_SLICES * OUTPUT_WIDTH;

  // ---------------------------------------------------------------------
  // FIFO
  // ---------------------------------------------------------------------
  logic [WIDTH-1:0]          mem [DEPTH];
  logic [MAX_DEPTH_BITS-1:0] wr_ptr;
  logic [MAX_DEPTH_BITS-1:0] rd_ptr;
  logic [MAX_DEPTH_BITS:0]   count;
  logic                      wr_accept;
  logic                      rd_accept;

  // A write while full is dropped even if a pop happens in the same cycle,
  // so acceptance looks only at the registered flags.
  assign wr_accept = bus.wr_en && !bus.full;
  assign rd_accept = bus.rd_en && !bus.empty;

  // Pointer and occupancy update; reset flushes the FIFO and beats wr/rd.
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // the pre-edge values of its neighbours regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_accept) wr_ptr <= wr_ptr + 1'b1;
      if (rd_accept) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_accept, rd_accept})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage write port.
  // NOTE: the storage array has no reset; the pointers and count define
  // which entries are valid, so clearing the array would only add logic.
  always_ff @(posedge clk) begin
    if (!reset && wr_accept) mem[wr_ptr] <= bus.din;
  end

  // Fall-through head and flags, all derived from registered state.
  assign bus.dout        = mem[rd_ptr];
  assign bus.full        = (count == DEPTH_CNT);
  assign bus.nearly_full = (count >= NEARLY_CNT);
  assign bus.empty       = (count == '0);

`ifdef FIFO_HASH_ERR_CHECK_EN
`ifndef SYNTHESIS
  // Simulation-only misuse reporting.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (bus.wr_en && bus.full)
        $display("ERROR: fallthrough_fifo_hash write while full at time %0t", $time);
      if (bus.rd_en && bus.empty)
        $display("ERROR: fallthrough_fifo_hash read while empty at time %0t", $time);
    end
  end
`endif
`endif

  // ---------------------------------------------------------------------
  // Hash
  // ---------------------------------------------------------------------
  function automatic logic [OUTPUT_WIDTH-1:0] rotl(input logic [OUTPUT_WIDTH-1:0] v,
                                                   input int r);
    logic [2*OUTPUT_WIDTH-1:0] dbl;
    dbl = {v, v} << r;
    return dbl[2*OUTPUT_WIDTH-1 -: OUTPUT_WIDTH];
  endfunction

  logic [PAD_WIDTH-1:0]    padded;
  logic [OUTPUT_WIDTH-1:0] slice;
  logic [OUTPUT_WIDTH-1:0] h0;
  logic [OUTPUT_WIDTH-1:0] h1;

  // The final slice is partial; zero-extending the tuple handles it.
  assign padded = PAD_WIDTH'(bus.data);

  // Fold the slices: plain XOR for index 0, per-slice rotation for index 1.
  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    h0    = '0;
    h1    = '0;
    slice = '0;
    for (int i = 0; i < NUM_SLICES; i++) begin
      slice = padded[i*OUTPUT_WIDTH +: OUTPUT_WIDTH];
      h0    = h0 ^ slice;
      h1    = h1 ^ rotl(slice, i % OUTPUT_WIDTH);
    end
  end

  assign bus.hash_0 = h0;
  assign bus.hash_1 = h1;

endmodule

// File: tb/tb_fallthrough_fifo_hash.sv
// Directed self-checking bench for fallthrough_fifo_hash.
module tb_fallthrough_fifo_hash;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  fallthrough_fifo_hash_if #(.WIDTH(72), .INPUT_WIDTH(96), .OUTPUT_WIDTH(19)) bus ();

  fallthrough_fifo_hash #(
    .WIDTH(72), .MAX_DEPTH_BITS(3), .INPUT_WIDTH(96), .OUTPUT_WIDTH(19)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge, then settle 1 time unit before sampling/driving.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [71:0] w);
    bus.din   = w;
    bus.wr_en = 1'b1;
    tick();
    bus.wr_en = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    checks++;
    if (bus.empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b want 1", bus.empty); end
    checks++;
    if (bus.full !== 1'b0) begin errors++; $display("FAIL reset_full got %b want 0", bus.full); end
    checks++;
    if (bus.nearly_full !== 1'b0) begin errors++; $display("FAIL reset_nearly_full got %b want 0", bus.nearly_full); end
  endtask

  task automatic test_single();
    bus.din   = 72'h11;
    bus.wr_en = 1'b1;
    checks++;
    if (bus.empty !== 1'b1) begin errors++; $display("FAIL single_pre_empty got %b want 1", bus.empty); end
    tick();
    bus.wr_en = 1'b0;
    checks++;
    if (bus.dout !== 72'h11) begin errors++; $display("FAIL single_dout got %h want 11", bus.dout); end
    checks++;
    if (bus.empty !== 1'b0) begin errors++; $display("FAIL single_empty got %b want 0", bus.empty); end
    bus.rd_en = 1'b1;
    tick();
    bus.rd_en = 1'b0;
    checks++;
    if (bus.empty !== 1'b1) begin errors++; $display("FAIL single_pop_empty got %b want 1", bus.empty); end
  endtask

  task automatic test_fill_drain();
    for (int i = 1; i <= 8; i++) begin
      push(72'(i));
      if (i == 7) begin
        checks++;
        if (bus.nearly_full !== 1'b1 || bus.full !== 1'b0) begin
          errors++; $display("FAIL fill7_flags got nf=%b f=%b want nf=1 f=0", bus.nearly_full, bus.full);
        end
      end
    end
    checks++;
    if (bus.full !== 1'b1) begin errors++; $display("FAIL fill8_full got %b want 1", bus.full); end
    push(72'hFF);
    checks++;
    if (bus.full !== 1'b1 || bus.dout !== 72'h1) begin
      errors++; $display("FAIL overflow got f=%b dout=%h want f=1 dout=1", bus.full, bus.dout);
    end
    for (int i = 1; i <= 8; i++) begin
      checks++;
      if (bus.dout !== 72'(i)) begin errors++; $display("FAIL drain_%0d got %h want %h", i, bus.dout, 72'(i)); end
      bus.rd_en = 1'b1;
      tick();
      bus.rd_en = 1'b0;
    end
    checks++;
    if (bus.empty !== 1'b1) begin errors++; $display("FAIL drain_empty got %b want 1", bus.empty); end
  endtask

  task automatic test_simultaneous();
    for (int i = 1; i <= 8; i++) push(72'(i));
    // Full: write must be dropped, pop of word 1 proceeds -> count 7.
    bus.din   = 72'hFF;
    bus.wr_en = 1'b1;
    bus.rd_en = 1'b1;
    tick();
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    checks++;
    if (bus.full !== 1'b0 || bus.nearly_full !== 1'b1) begin
      errors++; $display("FAIL full_rw_flags got f=%b nf=%b want f=0 nf=1", bus.full, bus.nearly_full);
    end
    checks++;
    if (bus.dout !== 72'h2) begin errors++; $display("FAIL full_rw_dout got %h want 2", bus.dout); end
    for (int i = 2; i <= 8; i++) begin
      checks++;
      if (bus.dout !== 72'(i) || bus.empty !== 1'b0) begin
        errors++; $display("FAIL full_rw_drain_%0d got %h e=%b want %h e=0", i, bus.dout, bus.empty, 72'(i));
      end
      bus.rd_en = 1'b1;
      tick();
      bus.rd_en = 1'b0;
    end
    checks++;
    if (bus.empty !== 1'b1) begin errors++; $display("FAIL full_rw_empty got %b want 1", bus.empty); end
    // Empty: pop ignored, write accepted -> count 1.
    bus.din   = 72'hAB;
    bus.wr_en = 1'b1;
    bus.rd_en = 1'b1;
    tick();
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    checks++;
    if (bus.empty !== 1'b0 || bus.dout !== 72'hAB || bus.nearly_full !== 1'b0) begin
      errors++; $display("FAIL empty_rw got e=%b dout=%h nf=%b want e=0 dout=ab nf=0",
                         bus.empty, bus.dout, bus.nearly_full);
    end
    bus.rd_en = 1'b1;
    tick();
    bus.rd_en = 1'b0;
    checks++;
    if (bus.empty !== 1'b1) begin errors++; $display("FAIL empty_rw_pop got %b want 1", bus.empty); end
  endtask

  task automatic test_reset_flush();
    for (int i = 0; i < 5; i++) push(72'h21 + 72'(i));
    bus.din   = 72'h77;
    bus.wr_en = 1'b1;
    reset     = 1'b1;
    tick();
    reset     = 1'b0;
    bus.wr_en = 1'b0;
    checks++;
    if (bus.empty !== 1'b1 || bus.full !== 1'b0 || bus.nearly_full !== 1'b0) begin
      errors++; $display("FAIL flush_flags got e=%b f=%b nf=%b want 1 0 0", bus.empty, bus.full, bus.nearly_full);
    end
    push(72'h55);
    checks++;
    if (bus.dout !== 72'h55 || bus.empty !== 1'b0) begin
      errors++; $display("FAIL flush_roundtrip got %h e=%b want 55 e=0", bus.dout, bus.empty);
    end
    bus.rd_en = 1'b1;
    tick();
    bus.rd_en = 1'b0;
    checks++;
    if (bus.empty !== 1'b1) begin errors++; $display("FAIL flush_pop got %b want 1", bus.empty); end
  endtask

  task automatic test_hash();
    logic [95:0] vec [4];
    logic [18:0] exp0 [4];
    logic [18:0] exp1 [4];
    vec[0] = 96'h0;                     exp0[0] = 19'h00000; exp1[0] = 19'h00000;
    vec[1] = 96'h1 << 19;               exp0[1] = 19'h00001; exp1[1] = 19'h00002;
    vec[2] = {96{1'b1}};                exp0[2] = 19'h7FFFE; exp1[2] = 19'h7FFDF;
    // Only bit 95 (slice 5, rotated by 5) plus bit 0 of slice 0.
    vec[3] = (96'h1 << 95) | 96'h1;     exp0[3] = 19'h00000; exp1[3] = 19'h00021;
    for (int i = 0; i < 4; i++) begin
      bus.data = vec[i];
      #1;
      checks++;
      if (bus.hash_0 !== exp0[i]) begin errors++; $display("FAIL hash0_v%0d got %h want %h", i, bus.hash_0, exp0[i]); end
      checks++;
      if (bus.hash_1 !== exp1[i]) begin errors++; $display("FAIL hash1_v%0d got %h want %h", i, bus.hash_1, exp1[i]); end
    end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    reset     = 1'b1;
    bus.din   = '0;
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    bus.data  = '0;
    test_reset();
    test_single();
    test_fill_drain();
    test_simultaneous();
    test_reset_flush();
    test_hash();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
